io_input_port: RTL

//   Input-side I/O port for the MIPS core: serves IN instructions that stall the PC until the user presses ENTER.

---
 rtl/io_input_port.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/io_input_port.sv
// -----------------------------------------------------------------------------
// io_input_port
//   Input-side I/O port for the MIPS core. Serves IN instructions by holding
//   the PC stalled until the user presses ENTER. Then it captures the switch
//   bank and releases the stall for exactly one cycle. During that cycle the
//   captured word is presented for register write-back.
//
//   The raw ENTER button and the switches are asynchronous. Each passes
//   through a two-flop synchroniser. The button is then debounced: a level
//   change is accepted only after DEBOUNCE_CYCLES consecutive stable cycles.
//
// Ports
//   clk            in   system clock, all state on rising edge
//   reset          in   synchronous, active-high
//   i_in_req       in   current instruction is IN (level, held while stalled)
//   i_btn_raw      in   raw ENTER push-button, asynchronous, active-high
//   i_sw_raw       in   raw switch bank [DATA_W-1:0], asynchronous
//   o_stall        out  PC hold request (combinational)
//   o_data_valid   out  1-cycle pulse: o_data_out is the IN result
//   o_data_out     out  last captured switch word, zero-extended to 32 bits
//   o_waiting      out  high while waiting for a press ("press ENTER" LED)
//   o_press_count  out  number of accepted captures, modulo 256
// -----------------------------------------------------------------------------
module io_input_port #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_req,
  input  logic              i_btn_raw,
  input  logic [DATA_W-1:0] i_sw_raw,
  output logic              o_stall,
  output logic              o_data_valid,
  output logic [31:0]       o_data_out,
  output logic              o_waiting,
  output logic [7:0]        o_press_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    CAPTURE
  } portState;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              r_btnS1;
  logic              r_btnS2;
  logic [DATA_W-1:0] r_swS1;
  logic [DATA_W-1:0] r_swS2;
  logic              r_btnDb;
  logic              r_btnDbQ;
  logic [CNT_W-1:0]  r_dbCnt;
  portState          r_state;
  portState          w_nextState;
  logic              w_press;
  logic              w_capture;
  logic [31:0]       w_swExt;
  logic [31:0]       r_dataOut;
  logic [7:0]        r_pressCount;

  // Two-flop synchronisers for the button and every switch bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btnS1 <= 1'b0;
      r_btnS2 <= 1'b0;
      r_swS1  <= '0;
      r_swS2  <= '0;
    end else begin
      r_btnS1 <= i_btn_raw;
      r_btnS2 <= r_btnS1;
      r_swS1  <= i_sw_raw;
      r_swS2  <= r_swS1;
    end
  end

  // Debounce: count consecutive cycles that disagree with the accepted level.
  // Any agreeing cycle restarts the count, so short glitches are never accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btnDb  <= 1'b0;
      r_btnDbQ <= 1'b0;
      r_dbCnt  <= '0;
    end else begin
      r_btnDbQ <= r_btnDb;
      if (r_btnS2 == r_btnDb) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt == DB_LAST) begin
        r_btnDb <= r_btnS2;
        r_dbCnt <= '0;
      end else begin
        r_dbCnt <= r_dbCnt + CNT_W'(1);
      end
    end
  end

  // A press is a rising edge of the debounced level; releases make no press.
  assign w_press   = r_btnDb & ~r_btnDbQ;
  assign w_capture = (r_state == WAIT_PRESS) & i_in_req & w_press;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A flushed IN (in_req low) has priority over a press.
  // Presses seen in IDLE are dropped rather than queued.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_in_req) begin
          w_nextState = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!i_in_req) begin
          w_nextState = IDLE;
        end else if (w_press) begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Outputs. Stall drops during CAPTURE, so the PC advances at the end of
  // the data_valid cycle.
  always_comb begin
    o_stall      = i_in_req & (r_state != CAPTURE);
    o_data_valid = (r_state == CAPTURE);
    o_waiting    = (r_state == WAIT_PRESS);
  end

  // Zero-extend the synchronised switches to the 32-bit data word.
  always_comb begin
    w_swExt               = '0;
    w_swExt[DATA_W-1:0]   = r_swS2;
  end

  // Capture register and press counter; data holds between captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut    <= '0;
      r_pressCount <= '0;
    end else if (w_capture) begin
      r_dataOut    <= w_swExt;
      r_pressCount <= r_pressCount + 8'd1;
    end
  end

  assign o_data_out    = r_dataOut;
  assign o_press_count = r_pressCount;

endmodule
